digit_serial_addsub: RTL and testbench
======================================

Name: digit_serial_addsub

Overview:
- Parametrised multi-cycle adder/subtractor; successor to the single-bit full-adder cell.
- Processes two WIDTH-bit operands DIGIT bits per clock, LSB digit first, using a registered carry between digits.
- Supports add-with-carry-in and two's-complement subtract, and reports carry/borrow and signed overflow.
- Sits in the datapath wherever area matters more than latency; start/done handshake to the controlling FSM.

Parameters:
- WIDTH, 8, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 2, bits processed per RUN cycle; 1 <= DIGIT <= WIDTH; N = WIDTH/DIGIT RUN cycles per operation.

Ports:
- iClk  input  1  clock; all state changes on rising edge.
- iRst  input  1  synchronous, active-high reset.
- iStart  input  1  request a new operation; sampled only in IDLE or DONE.
- iSub  input  1  0 = A+B+iC, 1 = A-B; captured at start.
- iA  input  WIDTH  operand A; captured at start.
- iB  input  WIDTH  operand B; captured at start.
- iC  input  1  carry-in for add; ignored when iSub=1; captured at start.
- oS  output  WIDTH  result; holds the last completed result.
- oC  output  1  carry-out of MSB (subtract: 1 = no borrow).
- oV  output  1  signed overflow = carry into MSB XOR carry out of MSB.
- oBusy  output  1  high in RUN.
- oDone  output  1  one-cycle pulse, high in DONE.

Behaviour:
- States: IDLE, RUN, DONE. Reset -> IDLE; oS=0, oC=0, oV=0, oBusy=0, oDone=0; digit counter and carry register cleared.
- IDLE: iStart=1 at edge k -> capture iA, iSub, iC; capture B as iSub ? ~iB : iB; init carry = iSub ? 1 : iC; counter=0; go to RUN.
- RUN: each edge adds one DIGIT slice plus the carry register.
  - Write the slice sum into the internal result shift register; update the carry; increment the counter.
  - At edge k+N the last digit is processed. oS, oC and oV are loaded from the completed sum and the final carries. State goes to DONE.
- oBusy is high for exactly N cycles (edges k+1..k+N). oDone is high for exactly the one cycle after edge k+N. Latency is N edges from the accepting edge.
- DONE: returns to IDLE next edge. iStart=1 in DONE is accepted exactly as in IDLE (go to RUN), giving back-to-back throughput of one op per N+1 cycles.
- iStart, iA, iB, iC and iSub are ignored in RUN. Operand changes during RUN do not affect the result.
- oS, oC and oV change only on the edge entering DONE (or on reset). They hold their values through IDLE and subsequent RUN cycles.
- Arithmetic is modulo 2^WIDTH. oV is computed from the MSB-digit internal carry, independent of DIGIT.
- DIGIT=WIDTH: N=1; the block degenerates to a one-cycle registered adder with the same handshake.
- Reset asserted in any state, including mid-RUN: the operation is aborted with no oDone pulse, and all outputs return to reset values on that edge.
- Reset has priority over iStart on the same edge.

Test Plan (WIDTH=8, DIGIT=2, N=4):
- Reset: hold iRst 2 cycles with iStart=1 -> oS=0x00, oC=0, oV=0, oBusy=0, oDone=0; no operation starts.
- Add with carry-in:
  - 0xFF+0x01, iC=0, start at edge k -> oBusy high for 4 cycles; oDone pulses 1 cycle after edge k+4; oS=0x00, oC=1, oV=0.
  - 0x10+0x20, iC=1 -> oS=0x31, oC=0.
- Signed overflow add: 0x7F+0x01 -> oS=0x80, oC=0, oV=1.
- Subtract:
  - 0x05-0x07 (iC=1, ignored) -> oS=0xFE, oC=0, oV=0.
  - 0x80-0x01 -> oS=0x7F, oC=1, oV=1.
- Handshake:
  - Hold iStart high and change iA to 0xAA during RUN of 0x03+0x04 -> single oDone; oS=0x07.
  - iStart high in DONE cycle with 0x01+0x01 -> next oDone 5 cycles later; oS=0x02.
- Reset mid-op: start 0x12+0x34, assert iRst at the 2nd RUN cycle -> oBusy=0 next cycle, no oDone, oS=0x00. A following start of 0x12+0x34 -> oS=0x46.

Source files
------------

// File: rtl/digit_serial_addsub_if.sv
// Operand/result bus between a controlling FSM and the digit-serial add/sub unit.
// Latency: none, this is wiring only.
// Backpressure: none; the start/done handshake is the only flow control.
interface digit_serial_addsub_if #(
    parameter int WIDTH = 8
);
    logic             iStart;
    logic             iSub;
    logic [WIDTH-1:0] iA;
    logic [WIDTH-1:0] iB;
    logic             iC;
    logic [WIDTH-1:0] oS;
    logic             oC;
    logic             oV;
    logic             oBusy;
    logic             oDone;

    // Controller side: issues operations and watches for completion.
    modport master (
        output iStart, iSub, iA, iB, iC,
        input  oS, oC, oV, oBusy, oDone
    );

    // Arithmetic unit side.
    modport slave (
        input  iStart, iSub, iA, iB, iC,
        output oS, oC, oV, oBusy, oDone
    );
endinterface

// File: rtl/digit_serial_addsub.sv
// Digit-serial adder/subtractor: DIGIT bits per cycle, LSB digit first, registered carry.
// Latency: WIDTH/DIGIT cycles from the accepting edge to the edge entering DONE.
// Backpressure: iStart is ignored while busy; a new op is accepted in IDLE or DONE.
module digit_serial_addsub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic                  iClk,
    input  logic                  iRst,
    digit_serial_addsub_if.slave  bus
);
    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               c_q, c_d;
    logic               v_q, v_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [DIGIT-1:0]   slice_a;
    logic [DIGIT-1:0]   slice_b;
    logic [DIGIT:0]     slice_sum;
    logic               msb_cin;
    logic [WIDTH-1:0]   sum_next;
    logic               last_digit;

    // Datapath for one digit: operands are consumed from the bottom, results enter at the top.
    always_comb begin
        slice_a   = a_q[DIGIT-1:0];
        slice_b   = b_q[DIGIT-1:0];
        slice_sum = {1'b0, slice_a} + {1'b0, slice_b} + {{DIGIT{1'b0}}, carry_q};
        // Carry into the top bit of this digit, recovered from sum = a ^ b ^ cin.
        msb_cin   = slice_sum[DIGIT-1] ^ slice_a[DIGIT-1] ^ slice_b[DIGIT-1];
        sum_next  = (sum_q >> DIGIT)
                  | ({{(WIDTH-DIGIT){1'b0}}, slice_sum[DIGIT-1:0]} << (WIDTH - DIGIT));
        last_digit = (cnt_q == CNT_W'(N - 1));
    end

    // Next-state and next-output logic for the IDLE/RUN/DONE controller.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        s_d     = s_q;
        c_d     = c_q;
        v_d     = v_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                busy_d = 1'b0;
                if (state_q == DONE) begin
                    state_d = IDLE;
                end
                if (bus.iStart) begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                    a_d     = bus.iA;
                    b_d     = bus.iSub ? ~bus.iB : bus.iB;
                    carry_d = bus.iSub ? 1'b1 : bus.iC;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                sum_d   = sum_next;
                carry_d = slice_sum[DIGIT];
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_digit) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    s_d     = sum_next;
                    c_d     = slice_sum[DIGIT];
                    v_d     = slice_sum[DIGIT] ^ msb_cin;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State register; reset wins over any pending start and aborts a running op.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            s_q     <= s_d;
            c_q     <= c_d;
            v_q     <= v_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.oS    = s_q;
    assign bus.oC    = c_q;
    assign bus.oV    = v_q;
    assign bus.oBusy = busy_q;
    assign bus.oDone = done_q;
endmodule

// File: tb/tb_digit_serial_addsub.sv
// Self-checking bench for digit_serial_addsub with WIDTH=8, DIGIT=2.
// Expected results are queued at start and compared when oDone pulses.
// Each scenario runs as its own task from a single initial block.
module tb_digit_serial_addsub;
    typedef struct packed {
        logic [7:0] s;
        logic       c;
        logic       v;
    } exp_t;

    logic iClk = 1'b0;
    logic iRst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic [7:0] last_s = 8'h00;

    digit_serial_addsub_if #(.WIDTH(8)) bus ();

    digit_serial_addsub #(.WIDTH(8), .DIGIT(2)) dut (
        .iClk (iClk),
        .iRst (iRst),
        .bus  (bus)
    );

    always #5 iClk = ~iClk;

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                   input logic c, input logic sub);
        exp_t       e;
        logic [7:0] bb;
        logic [8:0] t;
        bb  = sub ? ~b : b;
        t   = {1'b0, a} + {1'b0, bb} + {8'h00, (sub ? 1'b1 : c)};
        e.s = t[7:0];
        e.c = t[8];
        e.v = (a[7] == bb[7]) && (t[7] != a[7]);
        return e;
    endfunction

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b,
                         input logic c, input logic sub);
        bus.iA     = a;
        bus.iB     = b;
        bus.iC     = c;
        bus.iSub   = sub;
        bus.iStart = 1'b1;
        sb.push_back(model(a, b, c, sub));
    endtask

    task automatic compare_result(input string name);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: oDone with empty scoreboard", name);
        end else begin
            e = sb.pop_front();
            if ({bus.oS, bus.oC, bus.oV} !== {e.s, e.c, e.v}) begin
                errors++;
                $display("FAIL %s: got S=%h C=%b V=%b expected S=%h C=%b V=%b",
                         name, bus.oS, bus.oC, bus.oV, e.s, e.c, e.v);
            end
            last_s = e.s;
        end
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic c, input logic sub, input string name);
        int   cyc;
        int   busy_n;
        logic done_seen;
        logic hold_ok;
        drive(a, b, c, sub);
        step();
        bus.iStart = 1'b0;
        cyc = 0; busy_n = 0; done_seen = 1'b0; hold_ok = 1'b1;
        while (!done_seen && cyc < 20) begin
            if (bus.oDone) begin
                done_seen = 1'b1;
            end else begin
                if (bus.oBusy) busy_n++;
                if (bus.oS !== last_s) hold_ok = 1'b0;
                step();
                cyc++;
            end
        end
        checks++;
        if (!done_seen || cyc != 4) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles (done=%b) expected 4", name, cyc, done_seen);
        end
        checks++;
        if (busy_n != 4 || bus.oBusy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy: got %0d busy cycles, busy at done=%b expected 4 and 0",
                     name, busy_n, bus.oBusy);
        end
        checks++;
        if (!hold_ok) begin
            errors++;
            $display("FAIL %s hold: oS changed during RUN, expected to stay %h", name, last_s);
        end
        if (done_seen) compare_result(name);
        else if (sb.size() > 0) void'(sb.pop_front());
        step();
        checks++;
        if (bus.oDone !== 1'b0) begin
            errors++;
            $display("FAIL %s done_pulse: oDone=%b one cycle later expected 0", name, bus.oDone);
        end
    endtask

    task automatic test_reset();
        iRst = 1'b1;
        drive(8'h55, 8'h11, 1'b1, 1'b0);
        void'(sb.pop_back());
        step();
        step();
        checks++;
        if ({bus.oS, bus.oC, bus.oV, bus.oBusy, bus.oDone} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: got S=%h C=%b V=%b busy=%b done=%b expected all 0",
                     bus.oS, bus.oC, bus.oV, bus.oBusy, bus.oDone);
        end
        iRst = 1'b0;
        bus.iStart = 1'b0;
        step();
        checks++;
        if (bus.oBusy !== 1'b0 || bus.oDone !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_start: busy=%b done=%b expected 0 0", bus.oBusy, bus.oDone);
        end
        last_s = 8'h00;
    endtask

    task automatic test_add();
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, "add_ff_01");
        run_op(8'h10, 8'h20, 1'b1, 1'b0, "add_cin");
        run_op(8'h7F, 8'h01, 1'b0, 1'b0, "add_ovf");
    endtask

    task automatic test_sub();
        run_op(8'h05, 8'h07, 1'b1, 1'b1, "sub_borrow");
        run_op(8'h80, 8'h01, 1'b0, 1'b1, "sub_ovf");
    endtask

    task automatic test_hold_start();
        int done_n;
        drive(8'h03, 8'h04, 1'b0, 1'b0);
        step();
        bus.iA = 8'hAA;
        bus.iB = 8'h55;
        done_n = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.oDone) begin
                done_n++;
                if (done_n == 1) compare_result("hold_start_result");
                bus.iStart = 1'b0;
            end
            step();
        end
        bus.iStart = 1'b0;
        checks++;
        if (done_n != 1) begin
            errors++;
            $display("FAIL hold_start_done_count: got %0d pulses expected 1", done_n);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        drive(8'h10, 8'h20, 1'b1, 1'b0);
        step();
        bus.iStart = 1'b0;
        cyc = 0;
        while (!bus.oDone && cyc < 20) begin
            step();
            cyc++;
        end
        compare_result("b2b_first");
        drive(8'h01, 8'h01, 1'b0, 1'b0);
        step();
        bus.iStart = 1'b0;
        cyc = 1;
        while (!bus.oDone && cyc < 20) begin
            step();
            cyc++;
        end
        checks++;
        if (cyc != 5) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d cycles between done pulses expected 5", cyc);
        end
        compare_result("b2b_second");
        step();
    endtask

    task automatic test_reset_mid_op();
        int done_n;
        drive(8'h12, 8'h34, 1'b0, 1'b0);
        void'(sb.pop_back());
        step();
        bus.iStart = 1'b0;
        step();
        iRst = 1'b1;
        step();
        iRst = 1'b0;
        checks++;
        if (bus.oBusy !== 1'b0 || bus.oDone !== 1'b0 || bus.oS !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset: busy=%b done=%b S=%h expected 0 0 00",
                     bus.oBusy, bus.oDone, bus.oS);
        end
        last_s = 8'h00;
        done_n = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.oDone) done_n++;
            step();
        end
        checks++;
        if (done_n != 0) begin
            errors++;
            $display("FAIL mid_reset_no_done: got %0d pulses expected 0", done_n);
        end
        run_op(8'h12, 8'h34, 1'b0, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        bus.iStart = 1'b0;
        bus.iSub   = 1'b0;
        bus.iA     = 8'h00;
        bus.iB     = 8'h00;
        bus.iC     = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_hold_start();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
